// File: rtl/dmem_mmio_pkg.sv
// Typed views of the memory-map constants plus the byte-merge helper.
package dmem_mmio_pkg;
`include "mem_map.vh"

  localparam logic [3:0] MMIO_REGION  = `MMIO_REGION;
  localparam logic [3:0] OFF_GPIO     = `MMIO_GPIO;
  localparam logic [3:0] OFF_CYCLE_LO = `MMIO_CYCLE_LO;
  localparam logic [3:0] OFF_CYCLE_HI = `MMIO_CYCLE_HI;
  localparam logic [3:0] OFF_UART     = `MMIO_UART;

  localparam logic [1:0] UART_IDLE  = `UART_ST_IDLE;
  localparam logic [1:0] UART_START = `UART_ST_START;
  localparam logic [1:0] UART_DATA  = `UART_ST_DATA;
  localparam logic [1:0] UART_STOP  = `UART_ST_STOP;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++)
      if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
    return res;
  endfunction
endpackage

// File: rtl/mem_map.vh
// Shared memory-map constants for dmem_mmio, its test programs and the bench.
`ifndef MEM_MAP_VH
`define MEM_MAP_VH

`define MMIO_REGION   4'hF
`define MMIO_GPIO     4'h0
`define MMIO_CYCLE_LO 4'h1
`define MMIO_CYCLE_HI 4'h2
`define MMIO_UART     4'h3

`define UART_ST_IDLE  2'd0
`define UART_ST_START 2'd1
`define UART_ST_DATA  2'd2
`define UART_ST_STOP  2'd3

`endif

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit.
module uart_tx
  import dmem_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_tx
);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [1:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= UART_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      // Baud count restarts on every bit boundary and is parked at 0 while idle.
      if (state == UART_IDLE) baud <= '0;
      else                    baud <= bit_end ? '0 : baud + BW'(1);
      case (state)
        UART_IDLE:
          if (i_valid) begin
            state <= UART_START;
            shreg <= i_data;
          end
        UART_START:
          if (bit_end) begin
            state   <= UART_DATA;
            bit_cnt <= '0;
          end
        UART_DATA:
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= UART_STOP;
          end
        UART_STOP:
          if (bit_end) state <= UART_IDLE;
        default: state <= UART_IDLE;
      endcase
    end
  end

  always_comb begin
    o_tx = 1'b1;
    case (state)
      UART_START: o_tx = 1'b0;
      UART_DATA:  o_tx = shreg[0];
      default:    o_tx = 1'b1;
    endcase
  end

  assign o_busy = (state != UART_IDLE);
endmodule

// File: rtl/dmem_mmio.sv
// Data-memory responder: block RAM plus GPIO, 64-bit cycle counter and UART MMIO.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] i_mem_addr,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_we,
  input  logic [3:0]  i_mem_mask,
  output logic [31:0] o_mem_data,
  output logic [31:0] o_gpio,
  output logic        o_uart_tx
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          is_mmio;
  logic [3:0]    off;
  logic [AW-1:0] idx;
  logic          addr_unused;

  assign is_mmio     = (i_mem_addr[29:26] == MMIO_REGION);
  assign off         = i_mem_addr[3:0];
  assign idx         = i_mem_addr[AW-1:0];
  assign addr_unused = ^i_mem_addr;

  logic [31:0] ram [DEPTH];
  logic [31:0] ram_q;

  // Not reset-gated; the registered read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (i_mem_we && !is_mmio)
      for (int b = 0; b < 4; b++)
        if (i_mem_mask[b]) ram[idx][8*b +: 8] <= i_mem_data[8*b +: 8];
    ram_q <= ram[idx];
  end

  logic [63:0] cycle;
  logic [31:0] hi_snap;
  logic [31:0] gpio;
  logic [31:0] mmio_rd;
  logic [31:0] mmio_q;
  logic        sel_mmio_q;
  logic        uart_busy;
  logic        uart_start;

  assign uart_start = i_mem_we && is_mmio && (off == OFF_UART) && i_mem_mask[0];

  always_comb begin
    mmio_rd = '0;
    case (off)
      OFF_GPIO:     mmio_rd = gpio;
      OFF_CYCLE_LO: mmio_rd = cycle[31:0];
      OFF_CYCLE_HI: mmio_rd = hi_snap;
      OFF_UART:     mmio_rd = {31'b0, uart_busy};
      default:      mmio_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle      <= '0;
      hi_snap    <= '0;
      gpio       <= '0;
      mmio_q     <= '0;
      // Selecting the zeroed MMIO path forces o_mem_data to 0 without resetting the RAM read port.
      sel_mmio_q <= 1'b1;
    end else begin
      cycle      <= cycle + 64'd1;
      mmio_q     <= mmio_rd;
      sel_mmio_q <= is_mmio;
      if (is_mmio && off == OFF_CYCLE_LO) hi_snap <= cycle[63:32];
      if (i_mem_we && is_mmio && off == OFF_GPIO)
        gpio <= merge_bytes(gpio, i_mem_data, i_mem_mask);
    end
  end

  assign o_mem_data = sel_mmio_q ? mmio_q : ram_q;
  assign o_gpio     = gpio;

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk     (clk),
    .rst     (rst),
    .i_valid (uart_start),
    .i_data  (i_mem_data[7:0]),
    .o_busy  (uart_busy),
    .o_tx    (o_uart_tx)
  );
endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized + directed scoreboard bench for dmem_mmio against a cycle-level reference model.
module tb_dmem_mmio;
  import dmem_mmio_pkg::*;

  localparam int DEPTH = 256;
  localparam int CPB   = 4;
  localparam int AW    = 8;

  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic [29:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [3:0]  mask = '0;
  logic [31:0] rdata, gpio_o;
  logic        tx;

  dmem_mmio #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_mem_addr (addr),
    .i_mem_data (wdata),
    .i_mem_we   (we),
    .i_mem_mask (mask),
    .o_mem_data (rdata),
    .o_gpio     (gpio_o),
    .o_uart_tx  (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk_data;
    logic [31:0] data;
    logic [31:0] gpio;
    logic        tx;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: values as they are during the current cycle.
  logic [63:0] m_cyc = '0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_gpio = '0;
  logic [31:0] m_ram [DEPTH];
  bit          m_known [DEPTH];
  bit          u_active = 0;
  longint      u_start = 0;
  logic [7:0]  u_byte = '0;
  longint      tick = 0;

  function automatic bit busy_at(longint t);
    return u_active && (t > u_start) && (t <= u_start + 10 * CPB);
  endfunction

  function automatic logic tx_at(longint t);
    longint k;
    if (!busy_at(t)) return 1'b1;
    k = (t - u_start - 1) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return u_byte[k - 1];
  endfunction

  function automatic logic [29:0] mmio_a(input logic [3:0] o);
    return {MMIO_REGION, 22'b0, o};
  endfunction

  // One bus cycle: drive inputs, push what the outputs must be after the edge, advance the model.
  task automatic cyc(input logic r, input logic [29:0] a, input logic [31:0] d,
                     input logic w, input logic [3:0] m, input string nm);
    exp_t        e;
    bit          mm;
    logic [3:0]  o;
    logic [AW-1:0] ix;
    rst = r; addr = a; wdata = d; we = w; mask = m;
    mm = (a[29:26] == 4'hF);
    o  = a[3:0];
    ix = a[AW-1:0];
    e.name = nm;
    e.chk_data = 1;
    e.data = '0;
    if (r) e.data = '0;
    else if (mm) begin
      if      (o == 4'h0) e.data = m_gpio;
      else if (o == 4'h1) e.data = m_cyc[31:0];
      else if (o == 4'h2) e.data = m_hi;
      else if (o == 4'h3) e.data = {31'b0, busy_at(tick)};
      else                e.data = '0;
    end else begin
      e.data = m_ram[ix];
      e.chk_data = m_known[ix];
    end
    if (w && !mm) begin
      for (int b = 0; b < 4; b++)
        if (m[b]) m_ram[ix][8*b +: 8] = d[8*b +: 8];
      if (m == 4'hF) m_known[ix] = 1;
    end
    if (r) begin
      m_cyc = '0; m_hi = '0; m_gpio = '0; u_active = 0;
    end else begin
      if (mm && o == 4'h1) m_hi = m_cyc[63:32];
      m_cyc = m_cyc + 64'd1;
      if (w && mm && o == 4'h0)
        for (int b = 0; b < 4; b++)
          if (m[b]) m_gpio[8*b +: 8] = d[8*b +: 8];
      if (w && mm && o == 4'h3 && m[0] && !busy_at(tick)) begin
        u_active = 1; u_start = tick; u_byte = d[7:0];
      end
    end
    tick++;
    e.gpio = m_gpio;
    e.tx   = tx_at(tick);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic preload_cycle(input logic [63:0] v);
    force dut.cycle = v;
    #1;
    release dut.cycle;
    m_cyc = v;
  endtask

  task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: compares every registered output one step after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_data) check(e.name, "data", rdata, e.data);
        check(e.name, "gpio", gpio_o, e.gpio);
        check(e.name, "tx", {31'b0, tx}, {31'b0, e.tx});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [29:0] a;
    logic [3:0]  o;
    for (int i = 0; i < DEPTH; i++) begin m_ram[i] = '0; m_known[i] = 0; end
    @(negedge clk);
    repeat (3) cyc(1, mmio_a(OFF_GPIO), '0, 0, 4'h0, "reset");

    // Byte-masked RAM stores.
    cyc(0, 30'd5, 32'hDEADBEEF, 1, 4'hF, "w5_full");
    cyc(0, 30'd5, 32'h00005500, 1, 4'h2, "w5_byte1");
    cyc(0, 30'd5, '0, 0, 4'h0, "r5");
    // Read-first on a same-cycle read/write, then aliasing.
    cyc(0, 30'd7, 32'h1, 1, 4'hF, "w7_old");
    cyc(0, 30'd7, 32'h2, 1, 4'hF, "rw7_same");
    cyc(0, 30'd7, '0, 0, 4'h0, "r7_new");
    cyc(0, 30'(DEPTH + 7), '0, 0, 4'h0, "r7_alias");

    // GPIO write then reset.
    cyc(0, mmio_a(OFF_GPIO), 32'hA5A50F0F, 1, 4'hF, "gpio_w");
    cyc(0, mmio_a(OFF_GPIO), '0, 0, 4'h0, "gpio_r");
    cyc(0, mmio_a(OFF_CYCLE_HI), 32'h1234, 1, 4'hF, "ro_write");
    cyc(1, mmio_a(OFF_GPIO), 32'hFFFFFFFF, 1, 4'hF, "gpio_rst");
    cyc(0, mmio_a(OFF_GPIO), '0, 0, 4'h0, "gpio_after_rst");

    // Cycle counter snapshot across the 32-bit carry.
    preload_cycle(64'h0000_0000_FFFF_FFFD);
    cyc(0, mmio_a(OFF_CYCLE_LO), '0, 0, 4'h0, "lo_read");
    repeat (4) cyc(0, 30'd5, '0, 0, 4'h0, "lo_gap");
    cyc(0, mmio_a(OFF_CYCLE_HI), '0, 0, 4'h0, "hi_snap");
    // And across the full 64-bit wrap.
    preload_cycle(64'hFFFF_FFFF_FFFF_FFFE);
    cyc(0, mmio_a(OFF_CYCLE_LO), '0, 0, 4'h0, "lo_wrap_a");
    cyc(0, mmio_a(OFF_CYCLE_LO), '0, 0, 4'h0, "lo_wrap_b");
    cyc(0, mmio_a(OFF_CYCLE_HI), '0, 0, 4'h0, "hi_wrap_b");
    cyc(0, mmio_a(OFF_CYCLE_LO), '0, 0, 4'h0, "lo_wrap_c");
    cyc(0, mmio_a(OFF_CYCLE_HI), '0, 0, 4'h0, "hi_wrap_c");

    // UART frame, dropped write while busy, polling busy.
    cyc(0, mmio_a(OFF_UART), 32'h55, 1, 4'h1, "uart_w55");
    for (int i = 1; i <= 41; i++)
      if (i == 10) cyc(0, mmio_a(OFF_UART), 32'hFF, 1, 4'h1, "uart_drop");
      else         cyc(0, mmio_a(OFF_UART), '0, 0, 4'h0, "uart_poll");
    // Back-to-back: hammer writes while busy, first idle cycle accepts.
    cyc(0, mmio_a(OFF_UART), 32'hA3, 1, 4'h1, "uart_wA3");
    for (int i = 1; i <= 41; i++)
      cyc(0, mmio_a(OFF_UART), 32'h3C, 1, 4'h1, "uart_b2b");
    repeat (11) cyc(0, mmio_a(OFF_UART), '0, 0, 4'h0, "uart_mid");
    cyc(1, mmio_a(OFF_UART), 32'h99, 1, 4'h1, "uart_rst");
    repeat (2) cyc(0, mmio_a(OFF_UART), '0, 0, 4'h0, "uart_post_rst");
    cyc(0, mmio_a(OFF_UART), 32'h0F, 1, 4'h1, "uart_w0F");
    repeat (42) cyc(0, mmio_a(OFF_UART), '0, 0, 4'h0, "uart_frame2");

    // Random traffic over RAM (with aliasing upper bits) and the whole MMIO offset space.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        o = 4'($urandom_range(0, 15));
        a = {MMIO_REGION, 22'($urandom), o};
      end else begin
        a = 30'($urandom);
        if (a[29:26] == 4'hF) a[29] = 1'b0;
        a[AW-1:0] = AW'($urandom_range(0, 15));
      end
      cyc(($urandom_range(0, 99) == 0), a, $urandom, $urandom_range(0, 1) == 1,
          4'($urandom), "random");
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-memory responder for the single-cycle core's load/store port. It serves word-addressed, byte-masked requests with one-cycle read latency. It decodes the address into a block RAM region and a small MMIO region: GPIO output register, 64-bit cycle counter, and an 8N1 UART transmitter. It sits directly on the core's `o_mem_*` / `i_mem_data` pins.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; power of two.
- `CLKS_PER_BIT`, 16: UART bit period in clocks; must be ≥2.
- `clk` input 1: single clock, all logic rising-edge.
- `rst` input 1: reset, **synchronous, active-high**.
- `i_mem_addr` input 30: word address (byte address [31:2]).
- `i_mem_data` input 32: store data.
- `i_mem_we` input 1: store strobe.
- `i_mem_mask` input 4: byte enables; bit i selects byte [8i+7:8i].
- `o_mem_data` output 32: load data, registered.
- `o_gpio` output 32: GPIO_OUT register.
- `o_uart_tx` output 1: serial line, idle high.

## Operation
- **Region decode.**
  - `i_mem_addr[29:26]==4'hF` selects MMIO (byte 0xF000_0000+). MMIO offset = `i_mem_addr[3:0]`.
  - All other addresses select RAM. RAM index = `i_mem_addr[log2(DEPTH)-1:0]`; aliasing/wrap is intended.
- **RAM.**
  - Store: bytes with mask=1 are written at the clock edge; other bytes keep their value.
  - Load: every cycle the word at the index is registered to `o_mem_data`.
  - Same-cycle read and write to one index returns the OLD word (read-first).
  - RAM contents are not affected by `rst`.
- **MMIO map** (word offsets):
  - 0x0 GPIO_OUT, read/write. Byte-masked writes, same as RAM.
  - 0x1 CYCLE_LO, read-only. A read also latches `cycle[63:32]` into the HI snapshot.
  - 0x2 CYCLE_HI, read-only. Returns the snapshot, not the live upper word.
  - 0x3 UART, write-only and read-only halves:
    - A write with `mask[0]=1` while idle starts a frame with `data[7:0]`.
    - A write while busy is dropped, with no queueing.
    - A read returns `{31'b0, busy}`.
  - Other offsets read 0; writes to them, and writes to read-only offsets, are ignored.
- **Cycle counter.** 64-bit, +1 every cycle, wraps from 2^64−1 to 0.
- **UART FSM.**
  - States: IDLE → START → DATA → STOP → IDLE.
  - Line level: START drives 0; DATA sends 8 bits LSB first; STOP drives 1.
  - Each bit is held exactly CLKS_PER_BIT cycles, using a bit counter (3b) and a baud counter.
  - busy = (state != IDLE).

## Timing
- Read latency 1: address presented in cycle N gives `o_mem_data` valid after edge N+1, stable through cycle N+1. This applies to RAM and MMIO alike.
- A write takes effect at the edge ending cycle N; a read of the same address in cycle N+1 sees the new value.
- CYCLE_LO read in cycle N returns the counter value at cycle N. A CYCLE_HI read in any later cycle returns bits [63:32] of that same value.
- UART timing for a write accepted in cycle N:
  - Cycle N+1: state=START and `o_uart_tx`=0.
  - Frame lasts 10×CLKS_PER_BIT cycles.
  - busy reads 1 from cycle N+1 through the last STOP cycle, and 0 the cycle after.
  - A new write is accepted in the first cycle busy reads 0, giving back-to-back frames with no extra idle.
- Reset values (cycle after `rst` sampled high): `o_mem_data`=0, `o_gpio`=0, `o_uart_tx`=1, UART state IDLE, cycle counter=0, HI snapshot=0.
- `rst` mid-frame aborts the UART: the line returns high on the next edge.
- `rst` held with `i_mem_we`=1: no MMIO write takes effect. The RAM write still occurs, since RAM is not reset-gated.

## Structure
- `mem_map.vh` holds the shared constants, for use by the core's test programs and the bench:
  - MMIO region tag `4'hF`.
  - Offset defines `MMIO_GPIO`, `MMIO_CYCLE_LO`, `MMIO_CYCLE_HI`, `MMIO_UART`.
  - UART state encodings.
- Sub-module `uart_tx` (CLKS_PER_BIT param) contains the FSM and shift register.
  - Ports: `clk`, `rst`, `i_valid`, `i_data[7:0]`, `o_busy`, `o_tx`.
  - The top-level block holds decode, RAM, GPIO, counter and the read mux.

## Test plan
- Write 0xDEADBEEF to word 5 with mask 4'b1111, then mask 4'b0010 with 0x0000_5500 → read word 5 returns 0xDEAD55EF one cycle after address.
- Read and write word 7 (old 0x1, new 0x2) in the same cycle → `o_mem_data`=0x1. Next-cycle read returns 0x2. Word DEPTH+7 aliases to word 7.
- Write 0xA5A5_0F0F to GPIO, reset 3 cycles later → `o_gpio` shows 0xA5A50F0F after the write edge, then 0 the cycle after `rst`.
- Preload counter near 2^32−1 (force, or run long), read CYCLE_LO then CYCLE_HI 5 cycles later → HI equals the upper word at LO-read time, not the incremented value.
- UART write 0x55 with CLKS_PER_BIT=4 → `o_uart_tx` shows 0, then 1,0,1,0,1,0,1,0, then 1, each 4 cycles. A second write at cycle 10 is dropped. busy polls 1 during the frame and 0 at cycle 41.
- Assert `rst` at cycle 12 of a UART frame → `o_uart_tx`=1 and busy=0 the next cycle. A fresh write afterward produces a full frame.
